// File: rtl/sevenseg_scan_n.sv
// Multiplexed seven-segment scanner for NDIGITS common-anode digits.
// A prescaler divides each digit slot into DIVIDE cycles. The first GUARD
// cycles of every slot keep all anodes off to suppress ghosting. Every output
// is registered, so the outputs after an edge reflect the state and inputs
// sampled at that edge.
module sevenseg_scan_n #(
  parameter int NDIGITS = 8,
  parameter int DIVIDE  = 100000,
  parameter int GUARD   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   hex_mode,
  input  logic                   lz_en,
  output logic [6:0]             segs_n,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an_n
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PW = $clog2(DIVIDE);
  localparam logic [PW-1:0] PC_LAST  = PW'(DIVIDE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;
  localparam logic [6:0]    SEG_DASH = 7'b0111111;

  logic [PW-1:0]      r_pcount;
  logic [IW-1:0]      r_idx;

  logic [NDIGITS-1:0] w_nz;
  logic [NDIGITS-1:0] w_upper_zero;
  logic [NDIGITS-1:0] w_lz;
  logic [NDIGITS-1:0] w_an_sel;
  logic               w_guard;
  logic [3:0]         w_val;
  logic               w_blank;
  logic               w_dp;
  logic               w_lz_sel;
  logic [6:0]         w_glyph;
  logic [6:0]         w_segs_next;
  logic               w_dpn_next;

  // Prescaler and digit index; the index advances on the last cycle of a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcount <= '0;
      r_idx    <= '0;
    end else if (r_pcount == PC_LAST) begin
      r_pcount <= '0;
      r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pcount <= r_pcount + 1'b1;
    end
  end

  // Per-digit helpers: zero detect, "this and all higher digits are zero",
  // leading-zero flag, and the one-hot anode select for the current index.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign w_nz[gi]     = |data[4*gi +: 4];
      assign w_an_sel[gi] = (r_idx == IW'(gi));
      if (gi == NDIGITS - 1) begin : g_top
        assign w_upper_zero[gi] = ~w_nz[gi];
      end else begin : g_mid
        assign w_upper_zero[gi] = ~w_nz[gi] & w_upper_zero[gi+1];
      end
      if (gi == 0) begin : g_lsd
        // The least significant digit always shows, so a value of 0 reads "0".
        assign w_lz[gi] = 1'b0;
      end else begin : g_msd
        assign w_lz[gi] = lz_en & w_upper_zero[gi];
      end
    end
  endgenerate

  // Guard window at slot start; with GUARD=0 the anodes are never forced off.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_pcount < PW'(GUARD));
    end
  endgenerate

  // Pick the current digit's value and per-digit flags by index.
  always_comb begin
    w_val    = '0;
    w_blank  = 1'b0;
    w_dp     = 1'b0;
    w_lz_sel = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_val    = data[4*k +: 4];
        w_blank  = blank[k];
        w_dp     = dp[k];
        w_lz_sel = w_lz[k];
      end
    end
  end

  // Glyph decode (gfedcba, active low); 10-15 show letters or a dash.
  always_comb begin
    w_glyph = SEG_OFF;
    case (w_val)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = hex_mode ? 7'b0001000 : SEG_DASH;
      4'hB: w_glyph = hex_mode ? 7'b0000011 : SEG_DASH;
      4'hC: w_glyph = hex_mode ? 7'b1000110 : SEG_DASH;
      4'hD: w_glyph = hex_mode ? 7'b0100001 : SEG_DASH;
      4'hE: w_glyph = hex_mode ? 7'b0000110 : SEG_DASH;
      4'hF: w_glyph = hex_mode ? 7'b0001110 : SEG_DASH;
    endcase
  end

  // Blank overrides everything; leading-zero suppression only hides segments.
  always_comb begin
    w_segs_next = (w_blank | w_lz_sel) ? SEG_OFF : w_glyph;
    w_dpn_next  = w_blank ? 1'b1 : ~w_dp;
  end

  // Output registers; reset turns the whole display dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_n   <= '1;
      segs_n <= SEG_OFF;
      dp_n   <= 1'b1;
    end else begin
      an_n   <= w_guard ? '1 : ~w_an_sel;
      segs_n <= w_segs_next;
      dp_n   <= w_dpn_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Self-checking bench for sevenseg_scan_n with NDIGITS=4, DIVIDE=4, GUARD=1.
// Expected outputs are queued before each edge and compared after it.
module tb_sevenseg_scan_n;

  localparam int ND = 4;
  localparam int DV = 4;
  localparam int GD = 1;
  localparam int NV = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        hex_mode = 1'b0;
  logic        lz_en = 1'b0;
  logic [6:0]  segs_n;
  logic        dp_n;
  logic [3:0]  an_n;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] segs;
    logic       dpn;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        hex;
    logic        lz;
    logic [1:0]  dig;
    logic [6:0]  segs;
    logic        dpn;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [NV];
  logic [6:0] g4321 [4];

  sevenseg_scan_n #(.NDIGITS(ND), .DIVIDE(DV), .GUARD(GD)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .dp       (dp),
    .blank    (blank),
    .hex_mode (hex_mode),
    .lz_en    (lz_en),
    .segs_n   (segs_n),
    .dp_n     (dp_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Queue the expectation, take one edge, then pop and compare.
  task automatic expect_edge(input string name, input logic [3:0] an,
                             input logic [6:0] segs, input logic dpn);
    exp_t e;
    e.an = an;
    e.segs = segs;
    e.dpn = dpn;
    sb.push_back(e);
    tick();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=empty_queue required=entry", name);
    end else begin
      e = sb.pop_front();
      cmp({name, "_an"}, {3'b000, an_n}, {3'b000, e.an});
      cmp({name, "_segs"}, segs_n, e.segs);
      cmp({name, "_dpn"}, {6'b000000, dp_n}, {6'b000000, e.dpn});
      $display("edge %s an_n=%b segs_n=%b dp_n=%b", name, an_n, segs_n, dp_n);
    end
  endtask

  // Edges 1..n after reset release with data=4321, no dp/blank.
  task automatic run_scan(input int n, input string tag);
    logic [3:0] one;
    logic [3:0] an;
    int pc;
    int id;
    one = 4'b0001;
    for (int e = 1; e <= n; e++) begin
      pc = (e - 1) % DV;
      id = ((e - 1) / DV) % ND;
      an = (pc < GD) ? 4'hF : ~(one << id);
      expect_edge($sformatf("%s_e%0d", tag, e), an, g4321[id], 1'b1);
    end
  endtask

  initial begin
    logic [3:0] one;
    one = 4'b0001;
    g4321[0] = 7'b1111001;
    g4321[1] = 7'b0100100;
    g4321[2] = 7'b0110000;
    g4321[3] = 7'b0011001;

    vecs[0]  = '{16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1, 7'b0100100, 1'b1};
    vecs[1]  = '{16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, 7'b0011001, 1'b1};
    vecs[2]  = '{16'hFEDA, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 7'b0001000, 1'b1};
    vecs[3]  = '{16'hFEDA, 4'h0, 4'h0, 1'b1, 1'b0, 2'd1, 7'b0100001, 1'b1};
    vecs[4]  = '{16'hFEDA, 4'h0, 4'h0, 1'b1, 1'b0, 2'd2, 7'b0000110, 1'b1};
    vecs[5]  = '{16'hFEDA, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3, 7'b0001110, 1'b1};
    vecs[6]  = '{16'hFEDA, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 7'b0111111, 1'b1};
    vecs[7]  = '{16'hFEDA, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1, 7'b0111111, 1'b1};
    vecs[8]  = '{16'hFEDA, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2, 7'b0111111, 1'b1};
    vecs[9]  = '{16'hFEDA, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, 7'b0111111, 1'b1};
    vecs[10] = '{16'h0050, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 7'b1111111, 1'b1};
    vecs[11] = '{16'h0050, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, 7'b1111111, 1'b1};
    vecs[12] = '{16'h0050, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 7'b0010010, 1'b1};
    vecs[13] = '{16'h0050, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 7'b1000000, 1'b1};
    vecs[14] = '{16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 7'b1000000, 1'b1};
    vecs[15] = '{16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 7'b1111111, 1'b1};
    vecs[16] = '{16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 7'b1111111, 1'b1};
    vecs[17] = '{16'h0050, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, 7'b1000000, 1'b1};
    vecs[18] = '{16'h4321, 4'h5, 4'h4, 1'b0, 1'b0, 2'd0, 7'b1111001, 1'b0};
    vecs[19] = '{16'h4321, 4'h5, 4'h4, 1'b0, 1'b0, 2'd1, 7'b0100100, 1'b1};
    vecs[20] = '{16'h4321, 4'h5, 4'h4, 1'b0, 1'b0, 2'd2, 7'b1111111, 1'b1};
    vecs[21] = '{16'h4321, 4'h5, 4'h4, 1'b0, 1'b0, 2'd3, 7'b0011001, 1'b1};
    vecs[22] = '{16'h9876, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 7'b0000010, 1'b1};
    vecs[23] = '{16'h9876, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1, 7'b1111000, 1'b1};
    vecs[24] = '{16'h9876, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2, 7'b0000000, 1'b1};
    vecs[25] = '{16'h9876, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, 7'b0010000, 1'b1};
    vecs[26] = '{16'hBC05, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 7'b0010010, 1'b1};
    vecs[27] = '{16'hBC05, 4'h0, 4'h0, 1'b1, 1'b0, 2'd2, 7'b1000110, 1'b1};
    vecs[28] = '{16'hBC05, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3, 7'b0000011, 1'b1};
    vecs[29] = '{16'h0050, 4'h8, 4'h0, 1'b0, 1'b1, 2'd3, 7'b1111111, 1'b0};
    vecs[30] = '{16'h0000, 4'h1, 4'h1, 1'b0, 1'b1, 2'd0, 7'b1111111, 1'b1};

    // Reset state.
    rst = 1'b1;
    expect_edge("reset", 4'hF, 7'b1111111, 1'b1);

    // Full scan timing with data=4321, including wrap back to digit 0.
    data = 16'h4321;
    dp = '0;
    blank = '0;
    hex_mode = 1'b0;
    lz_en = 1'b0;
    rst = 1'b0;
    run_scan(18, "scan");

    // Reset in digit 2 slot at pcount=2, then scan restarts from digit 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_scan(10, "pre");
    rst = 1'b1;
    expect_edge("midrst", 4'hF, 7'b1111111, 1'b1);
    rst = 1'b0;
    run_scan(6, "post");

    // Mid-slot data change shows one edge later without moving the slot.
    data = 16'h0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_edge("lat_e1", 4'hF, 7'b1000000, 1'b1);
    expect_edge("lat_e2", 4'hE, 7'b1000000, 1'b1);
    data = 16'h0008;
    expect_edge("lat_e3", 4'hE, 7'b0000000, 1'b1);
    expect_edge("lat_e4", 4'hE, 7'b0000000, 1'b1);
    expect_edge("lat_e5", 4'hF, 7'b1000000, 1'b1);

    // Decode vectors: each sampled at pcount=1 of its digit slot.
    for (int i = 0; i < NV; i++) begin
      data = vecs[i].data;
      dp = vecs[i].dp;
      blank = vecs[i].blank;
      hex_mode = vecs[i].hex;
      lz_en = vecs[i].lz;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= DV * int'(vecs[i].dig) + 1; e++) begin
        tick();
      end
      expect_edge($sformatf("vec%0d", i), ~(one << vecs[i].dig), vecs[i].segs, vecs[i].dpn);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_queue actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_n.md
SEVENSEG_SCAN_N -- requirements
Module: sevenseg_scan_n

Interface
REQ-001 SHALL have parameter NDIGITS, default 8, meaning number of multiplexed digits (legal 1..16).
REQ-002 SHALL have parameter DIVIDE, default 100000, meaning clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter GUARD, default 1, meaning anode-off cycles at slot start for ghosting suppression (legal 0..DIVIDE-1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port data  input  4*NDIGITS  digit values; data[4k+3:4k] is digit k; digit 0 least significant.
REQ-007 SHALL have port dp  input  NDIGITS  active-high decimal-point enable per digit.
REQ-008 SHALL have port blank  input  NDIGITS  active-high forced blank per digit.
REQ-009 SHALL have port hex_mode  input  1  1 = values 10-15 show A-F glyphs; 0 = values 10-15 show dash.
REQ-010 SHALL have port lz_en  input  1  1 = leading-zero suppression enabled.
REQ-011 SHALL have port segs_n  output  7  active-low segments, ordered g(6) down to a(0).
REQ-012 SHALL have port dp_n  output  1  active-low decimal point.
REQ-013 SHALL have port an_n  output  NDIGITS  active-low digit enables, an_n[k] selects digit k.

Function
REQ-014 SHALL hold prescaler pcount (0..DIVIDE-1) and digit index idx (0..NDIGITS-1).
REQ-015 SHALL increment pcount every cycle; at pcount==DIVIDE-1, pcount->0 and idx->idx+1, wrapping NDIGITS-1 -> 0.
REQ-016 SHALL register all outputs: outputs after edge t+1 are a function of pcount, idx and inputs sampled at edge t (one-cycle latency, no combinational input-to-output path).
REQ-017 SHALL drive an_n all ones when pcount < GUARD; otherwise an_n has only bit idx low.
REQ-018 SHALL decode digit value v = data[4*idx+3:4*idx] with gfedcba glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL, with hex_mode=1, decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 SHALL, with hex_mode=0, decode values 10-15 as dash 0111111.
REQ-021 SHALL treat digit k (k>=1) as a leading zero when lz_en=1 and digits k..NDIGITS-1 all have value 0; digit 0 is never a leading zero.
REQ-022 SHALL drive segs_n = 1111111 when the current digit is blanked (blank[idx]=1) or is a leading zero; blank takes priority over all decode.
REQ-023 SHALL drive dp_n = ~dp[idx] unless blank[idx]=1 (then dp_n=1); leading-zero suppression does not affect dp_n.
REQ-024 SHALL, with NDIGITS=1, keep idx=0 permanently and still apply GUARD each slot.
REQ-025 SHALL have full scan period NDIGITS*DIVIDE cycles, independent of input values.
REQ-026 SHALL accept input changes on any cycle; a change mid-slot takes effect on outputs one cycle later without restarting the slot.

Reset
REQ-027 SHALL, on a rising edge with rst=1, set pcount=0, idx=0, an_n=all ones, segs_n=1111111, dp_n=1.
REQ-028 SHALL give rst priority over prescaler advance; reset asserted mid-slot or mid-scan restarts at digit 0, slot cycle 0.
REQ-029 SHALL, at first edge after rst deasserts, produce outputs from pcount=0, idx=0 (an_n all ones if GUARD>=1).

Verification (NDIGITS=4, DIVIDE=4, GUARD=1)
REQ-030 Scan: data=16'h4321, dp=0, blank=0, lz_en=0, release reset -> edges 1..4 an_n=1111,1110,1110,1110 with segs_n=1111001; edge 5 an_n=1111; edges 6-8 an_n=1101 segs_n=0100100; digit 0 reselected at edge 17.
REQ-031 Hex mode: data=16'hFEDA, hex_mode=1 -> digits 0..3 show 0001000, 0100001, 0000110, 0001110; hex_mode=0 -> all four show 0111111.
REQ-032 Leading zeros: data=16'h0050, lz_en=1 -> digits 3 and 2 segs_n=1111111, digit 1 shows 0010010, digit 0 shows 1000000; data=0000 -> only digit 0 shows 1000000.
REQ-033 Blank/dp: dp=4'b0101, blank=4'b0100 -> dp_n=0 in digit 0 slot, dp_n=1 and segs_n=1111111 in digit 2 slot, dp_n=1 in digits 1,3.
REQ-034 Reset mid-scan: assert rst during digit 2 slot at pcount=2 -> next edge all outputs at reset values; after release, scan restarts at digit 0 per REQ-030 timing.
REQ-035 Latency: change data[3:0] 0->8 at pcount=2 of digit 0 slot -> segs_n becomes 0000000 exactly one edge later, slot boundary unchanged.
